mem_acc: RTL
============

# mem_acc

Parametrised memory accumulator that sums `len` consecutive words from an external ROM/RAM read port, starting at a programmable base address. It generalises the earlier fixed sync-read and async-read accumulators into one block whose read latency is a parameter (0 = async ROM, 1 = sync ROM, up to 4 for pipelined memories). It adds a start/busy/done handshake, an on-chip checksum compare and overflow detection. It sits between a ROM instance and the top-level LED/checksum logic.

## Interface
- `AWIDTH`, 10: address width.
- `DWIDTH`, 32: read data width.
- `RWIDTH`, 32: accumulator/result width; must be ≥ DWIDTH.
- `READ_LATENCY`, 1: cycles from `read_addr` to valid `read_data`; legal range 0..4.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled when not busy.
- `base_addr`  in  AWIDTH  first address; sampled with `start`.
- `len`  in  AWIDTH+1  word count, 0..2^AWIDTH; sampled with `start`.
- `expected`  in  RWIDTH  reference checksum; compared continuously.
- `read_en`  out  1  high in cycles that issue an address.
- `read_addr`  out  AWIDTH  memory address.
- `read_data`  in  DWIDTH  memory data, valid READ_LATENCY cycles after its address.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until next accepted `start` or reset.
- `acc_result`  out  RWIDTH  running/final sum.
- `match`  out  1  `done && acc_result == expected`.
- `overflow`  out  1  sticky: sum exceeded 2^RWIDTH−1 during this run.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE + `start`:
  - If `len`≠0: go to ISSUE. Clear `acc_result`, `overflow`, and `done`. Load the address counter with `base_addr` and the remaining count with `len`.
  - If `len`=0: go to DONE with `acc_result`=0.
- ISSUE:
  - Each cycle, `read_en`=1 and `read_addr`=counter. Increment the counter modulo 2^AWIDTH, so addresses wrap past the top. Decrement the remaining count.
  - When the final address has been issued: go to DRAIN if READ_LATENCY>0, else go to DONE.
- DRAIN: wait READ_LATENCY cycles for outstanding data, then go to DONE.
- Valid tracking: a READ_LATENCY-deep shift register carries `read_en`. When its output is 1, add `read_data`, zero-extended to RWIDTH, into `acc_result` at that edge. For READ_LATENCY=0 the add uses `read_data` in the same cycle as the address.
- Arithmetic: modulo 2^RWIDTH. A carry out sets `overflow`, which is sticky until the next accepted `start`.
- `start` while busy: ignored. `base_addr`/`len` changes mid-run: no effect.
- `rst_n` low at any time, including mid-run: all state cleared immediately; the in-flight run is abandoned.
- Reset values: `busy`=0, `done`=0, `read_en`=0, `read_addr`=0, `acc_result`=0, `match`=0, `overflow`=0.

## Timing
- Edge E0 samples `start`=1. ISSUE occupies cycles 1..len, one address per cycle with no bubbles.
- `done` rises in cycle len+READ_LATENCY+1 after E0. With `len`=0, `done` rises in cycle 1.
- `busy` = state ∈ {ISSUE, DRAIN}. `busy` and `done` are never both high.
- `read_addr`, `read_en`, `busy`, `done`, and `overflow` are registered. `match` is combinational from registered `done`, `acc_result`, and `expected`.
- Back-to-back runs: `start` in the first DONE cycle is accepted; the next ISSUE starts the following cycle.

## Configuration
- `MEM_ACC_SAT_EN` defined: on carry out, `acc_result` clamps to 2^RWIDTH−1 and stays there for the rest of the run. `overflow` is still set.
- `MEM_ACC_SAT_EN` undefined: wrap-around addition. `overflow` flags the wrap.

## Structure
- Package `mem_acc_pkg`:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - `MEM_ACC_MAX_LATENCY` = 4;
  - latency-range check constant used by an elaboration-time assertion.
- Sub-module `mem_acc_vpipe`:
  - parametrised valid delay line of depth READ_LATENCY, with reset to 0;
  - depth 0 is a wire.

## Test plan
- READ_LATENCY=0, ROM[i]=i, base 0, len 1024 → `acc_result`=523776. `done` in cycle 1025. `match`=1 with `expected`=523776.
- READ_LATENCY=1 and 3, same data and len 1024 → same sum. `done` in cycles 1026 and 1028 respectively.
- base 1020, len 8, AWIDTH=10, ROM[i]=i → addresses 1020..1023, 0..3 in order. Sum 4092.
- len 0 → `done` in cycle 1, `acc_result`=0, `read_en` never asserted. A `start` pulse during busy → ignored, result unchanged.
- RWIDTH=DWIDTH=8, ROM all 0xFF, len 4:
  - without `MEM_ACC_SAT_EN`: `acc_result`=0xFC, `overflow`=1;
  - with `MEM_ACC_SAT_EN`: `acc_result`=0xFF, `overflow`=1.
- `rst_n` pulsed low mid-ISSUE → all outputs 0 within the same cycle. A new `start` after release yields a correct full sum.

Source files
------------

// File: rtl/mem_acc_pkg.sv
// mem_acc shared types and constants.
// Provides the FSM state enum and the read-latency range check.
package mem_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MEM_ACC_MIN_LATENCY = 0;
    localparam int MEM_ACC_MAX_LATENCY = 4;

    function automatic bit latency_ok(input int lat);
        return (lat >= MEM_ACC_MIN_LATENCY) &&
               (lat <= MEM_ACC_MAX_LATENCY);
    endfunction

endpackage

// File: rtl/mem_acc_vpipe.sv
// Valid delay line of depth DEPTH; depth 0 is a plain wire.
// Ports: clk, rst_n (async, active low), vin, vout.
module mem_acc_vpipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vin,
    output logic vout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n};
        assign vout = vin;
    end else begin : g_pipe
        logic [DEPTH-1:0] sr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else begin
                sr[0] <= vin;
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end
        assign vout = sr[DEPTH-1];
    end

endmodule

// File: rtl/mem_acc.sv
// Memory accumulator: sums len words read from base_addr upward.
// Ports: clk, rst_n, start/base_addr/len (run request), expected,
//   read_en/read_addr/read_data (memory port), busy, done,
//   acc_result, match, overflow.
// Optional: define MEM_ACC_SAT_EN for a saturating accumulator.
module mem_acc
    import mem_acc_pkg::*;
#(
    parameter int AWIDTH       = 10,
    parameter int DWIDTH       = 32,
    parameter int RWIDTH       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    input  logic [RWIDTH-1:0] expected,
    output logic              read_en,
    output logic [AWIDTH-1:0] read_addr,
    input  logic [DWIDTH-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic [RWIDTH-1:0] acc_result,
    output logic              match,
    output logic              overflow
);

    if (!latency_ok(READ_LATENCY)) begin : g_bad_lat
        $error("mem_acc: READ_LATENCY out of range");
    end
    if (RWIDTH < DWIDTH) begin : g_bad_width
        $error("mem_acc: RWIDTH must be >= DWIDTH");
    end

    localparam logic [2:0] DRAIN_INIT =
        (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    state_t            state;
    logic [AWIDTH:0]   rem;
    logic [2:0]        dcnt;
    logic              vout;
    logic [RWIDTH:0]   sum;
    logic [RWIDTH-1:0] acc_nxt;

    mem_acc_vpipe #(
        .DEPTH (READ_LATENCY)
    ) u_vpipe (
        .clk   (clk),
        .rst_n (rst_n),
        .vin   (read_en),
        .vout  (vout)
    );

    // Bit RWIDTH of sum is the carry out of the modulo add.
    assign sum = {1'b0, acc_result} + (RWIDTH + 1)'(read_data);

`ifdef MEM_ACC_SAT_EN
    // Once clamped, stay at all-ones for the rest of the run.
    assign acc_nxt = (sum[RWIDTH] || overflow) ? '1 : sum[RWIDTH-1:0];
`else
    assign acc_nxt = sum[RWIDTH-1:0];
`endif

    assign match = done && (acc_result == expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            dcnt       <= '0;
            read_en    <= 1'b0;
            read_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            acc_result <= '0;
            overflow   <= 1'b0;
        end else begin
            if (vout) begin
                acc_result <= acc_nxt;
                if (sum[RWIDTH]) overflow <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc_result <= '0;
                        overflow   <= 1'b0;
                        if (len != '0) begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            read_en   <= 1'b1;
                            read_addr <= base_addr;
                            rem       <= len;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    read_addr <= read_addr + AWIDTH'(1);
                    rem       <= rem - (AWIDTH + 1)'(1);
                    if (rem == (AWIDTH + 1)'(1)) begin
                        read_en <= 1'b0;
                        if (READ_LATENCY > 0) begin
                            state <= DRAIN;
                            dcnt  <= DRAIN_INIT;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == 3'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
